// File: rtl/lbist_ctrl.sv
// LBIST sequencer: seeds the pattern generator, runs NUM_PATTERNS cycles compacting cut_resp into a MISR,
// then compares against GOLDEN_SIG. Outputs are registered from the next state, so done rises NUM_PATTERNS+3 edges after start is seen (counting that edge).
module lbist_ctrl #(
  parameter int unsigned       NUM_PATTERNS = 255,
  parameter int unsigned       CNT_W        = 8,
  parameter int unsigned       RESP_W       = 8,
  parameter logic [RESP_W-1:0] MISR_TAPS    = 8'hB8,
  parameter logic [RESP_W-1:0] MISR_SEED    = 8'h00,
  parameter logic [RESP_W-1:0] GOLDEN_SIG   = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [RESP_W-1:0] cut_resp,
  output logic              tpg_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature,
  output logic [CNT_W-1:0]  pat_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_COMPARE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_PATTERNS - 1);

  // The pattern counter must reach NUM_PATTERNS without wrapping.
  if (NUM_PATTERNS == 0 || NUM_PATTERNS > (2**CNT_W) - 1) begin : g_bad_num_patterns
    $error("lbist_ctrl: NUM_PATTERNS must be in 1..2**CNT_W-1");
  end

  state_t              r_state;
  state_t              w_next;
  logic                r_tpg_rst;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [RESP_W-1:0]   r_sig;
  logic [CNT_W-1:0]    r_pat_cnt;
  logic                w_fb;
  logic [RESP_W-1:0]   w_misr_next;

  assign w_fb        = ^(r_sig & MISR_TAPS);
  assign w_misr_next = {r_sig[RESP_W-2:0], w_fb} ^ cut_resp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_INIT;
      S_INIT:    w_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)                       w_next = S_IDLE;
        else if (r_pat_cnt == LP_LAST)   w_next = S_COMPARE;
      end
      S_COMPARE: w_next = S_DONE;
      S_DONE:    if (!start) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // An aborted INIT/RUN edge leaves signature/pat_cnt untouched and clears pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tpg_rst <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_sig     <= MISR_SEED;
      r_pat_cnt <= '0;
    end else begin
      r_tpg_rst <= (w_next != S_RUN);
      r_busy    <= (w_next == S_INIT) || (w_next == S_RUN) || (w_next == S_COMPARE);
      r_done    <= (w_next == S_DONE);
      case (r_state)
        S_INIT: begin
          r_pass <= 1'b0;
          if (!abort) begin
            r_sig     <= MISR_SEED;
            r_pat_cnt <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_pass <= 1'b0;
          end else begin
            r_sig     <= w_misr_next;
            r_pat_cnt <= r_pat_cnt + 1'b1;
          end
        end
        S_COMPARE: r_pass <= (r_sig == GOLDEN_SIG);
        default: ;
      endcase
    end
  end

  assign tpg_rst   = r_tpg_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;
  assign pat_cnt   = r_pat_cnt;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Scoreboarded bench for lbist_ctrl: runs are queued with their reference signature,
// a negedge monitor checks each completed run against the queue.
module tb_lbist_ctrl;

  localparam int         N    = 4;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h00;
  localparam logic [7:0] GOLD = 8'h0F;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cut_resp = 8'h00;
  logic       tpg_rst, busy, done, pass;
  logic [7:0] signature, pat_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] sig;
    logic       pass;
    logic [7:0] cnt;
    int         done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_done = 1'b0;
  int   low_cnt   = 0;

  lbist_ctrl #(
    .NUM_PATTERNS(N), .CNT_W(8), .RESP_W(8),
    .MISR_TAPS(TAPS), .MISR_SEED(SEED), .GOLDEN_SIG(GOLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cut_resp(cut_resp),
    .tpg_rst(tpg_rst), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_cnt(pat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference MISR: shift left, feed back parity of tapped bits, xor in the response.
  function automatic logic [7:0] misr_ref(input logic [7:0] seed, input logic [7:0] resp[$]);
    int s;
    int fb;
    s = seed;
    foreach (resp[i]) begin
      fb = $countones(8'(s) & TAPS) % 2;
      s  = (((s * 2) % 256) + fb) ^ int'(resp[i]);
    end
    return 8'(s);
  endfunction

  always @(negedge clk) begin
    if (!tpg_rst) low_cnt++;
    if (!busy && !done) low_cnt = 0;
    if (reset && done && !prev_done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no run pending (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("signature", signature, mon_e.sig);
        check("pass", pass, mon_e.pass);
        check("pat_cnt", pat_cnt, mon_e.cnt);
        check("done_latency", cyc, mon_e.done_cyc);
        check("tpg_rst_in_done", tpg_rst, 1);
        check("busy_in_done", busy, 0);
        check("tpg_rst_low_cycles", low_cnt, N);
      end
    end
    prev_done = done;
  end

  // kind: 0 random responses, 1 constant 01, 2 constant 00
  task automatic do_run(input int kind, input bit hold_start, input bit abort_with_start);
    logic [7:0] r[$];
    exp_t       e;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       r.push_back(8'($urandom_range(0, 255)));
        1:       r.push_back(8'h01);
        default: r.push_back(8'h00);
      endcase
    end
    e.sig      = misr_ref(SEED, r);
    e.pass     = (e.sig == GOLD);
    e.cnt      = 8'(N);
    e.done_cyc = cyc + 1 + N + 2;
    exp_q.push_back(e);
    start = 1'b1;
    abort = abort_with_start;
    @(negedge clk);
    abort = 1'b0;
    if (!hold_start) start = 1'b0;
    @(negedge clk);
    foreach (r[i]) begin
      cut_resp = r[i];
      @(negedge clk);
    end
    cut_resp = 8'($urandom_range(0, 255));
    for (int k = 0; k < 10 && !done; k++) @(negedge clk);
    check("done_timeout", done, 1);
    if (hold_start) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("no_retrigger_done", done, 1);
        check("no_retrigger_busy", busy, 0);
      end
      start = 1'b0;
    end
    @(negedge clk);
    check("back_to_idle", done, 0);
  endtask

  initial begin
    logic [7:0] two_ones[$];
    two_ones = '{8'h01, 8'h01};

    repeat (2) @(negedge clk);
    check("rst_tpg_rst", tpg_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_signature", signature, SEED);
    check("rst_pat_cnt", pat_cnt, 0);
    reset = 1'b1;
    @(negedge clk);

    do_run(1, 1'b0, 1'b0);
    do_run(2, 1'b0, 1'b0);
    do_run(1, 1'b0, 1'b0);

    // abort during INIT after a passing run: pass must drop
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_init_busy", busy, 0);
    check("abort_init_tpg_rst", tpg_rst, 1);
    check("abort_init_pass", pass, 0);
    @(negedge clk);

    // abort in RUN once pat_cnt reaches 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cut_resp = 8'h01;
      @(negedge clk);
    end
    check("pre_abort_pat_cnt", pat_cnt, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_run_busy", busy, 0);
    check("abort_run_done", done, 0);
    check("abort_run_tpg_rst", tpg_rst, 1);
    check("abort_run_signature", signature, misr_ref(SEED, two_ones));
    check("abort_run_pat_cnt", pat_cnt, 2);
    @(negedge clk);

    // abort alongside start in IDLE has no effect
    do_run(1, 1'b0, 1'b1);

    // asynchronous reset in the middle of RUN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cut_resp = 8'h01;
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check("async_rst_tpg_rst", tpg_rst, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_signature", signature, SEED);
    check("async_rst_pat_cnt", pat_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_run(1, 1'b0, 1'b0);

    do_run(1, 1'b1, 1'b0);
    do_run(1, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(($urandom_range(0, 7) == 0) ? 2 : 0, ($urandom_range(0, 3) == 0), 1'b0);
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
